// File: rtl/series_pkg.sv
// Types and constants shared by the series-engine host, its engine-side
// interface, and the engine itself.
package series_pkg;

  localparam int W_DEFAULT = 16;
  // Result width produced by the engine datapath
  localparam int RES_W     = W_DEFAULT;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/series_host_if.sv
// Host <-> series engine handshake: start pulse, operand stream, result return.
interface series_host_if
  import series_pkg::*;
#(
  parameter int W = W_DEFAULT
);

  logic         eng_start;
  logic         eng_in_valid;
  logic [W-1:0] eng_x;
  logic         eng_ready;
  logic         eng_out_valid;
  logic [W-1:0] eng_result;
  logic         eng_error;

  modport master (
    output eng_start, eng_in_valid, eng_x,
    input  eng_ready, eng_out_valid, eng_result, eng_error
  );

  modport slave (
    input  eng_start, eng_in_valid, eng_x,
    output eng_ready, eng_out_valid, eng_result, eng_error
  );

endinterface

// File: rtl/series_host_sync_fifo.sv
// Single-clock FIFO holding engine results until the consumer pops them.
// Push and pop may occur together in any fill state.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] P_ONE = (AW + 1)'(1);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: storage carries no reset; only the pointers do, and o_data is masked while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + P_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + P_ONE;
    end
  end

endmodule

// File: rtl/series_host.sv
// Host side of the series engine: buffers operands, starts the engine, streams
// one operand at a time and queues the returned results.
module series_host
  import series_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int DEPTH   = 8,
  parameter int RDEPTH  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ld_valid,
  input  logic [W-1:0] i_ld_data,
  output logic         o_ld_ready,
  input  logic         i_go,
  series_host_if.master eng,
  output logic         o_res_valid,
  output logic [W-1:0] o_res_data,
  input  logic         i_res_ready,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic [W-1:0]  r_buf [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_sent;
  logic [TW-1:0] r_timer;
  logic          r_err;

  logic          w_load;
  logic          w_xfer;
  logic          w_push;
  logic          w_timeout;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic [CW-1:0] w_sent_next;

  assign o_ld_ready       = (r_state == ST_IDLE) && (r_count < C_FULL) && !i_go;
  assign w_load           = i_ld_valid && o_ld_ready;
  assign w_timeout        = (r_timer == T_LAST);
  assign w_sent_next      = r_sent + C_ONE;

  // A raised in_valid cannot drop: nothing pushes while in SEND, so not-full persists
  assign eng.eng_start    = (r_state == ST_START);
  assign eng.eng_in_valid = (r_state == ST_SEND) && !w_fifo_full;
  assign eng.eng_x        = eng.eng_in_valid ? r_buf[r_rd_ptr[AW-1:0]] : '0;

  // Engine error and timeout win over a transfer or push in the same cycle
  assign w_xfer = eng.eng_in_valid && eng.eng_ready && !eng.eng_error && !w_timeout;
  assign w_push = (r_state == ST_WAIT) && eng.eng_out_valid && !eng.eng_error && !w_timeout;

  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_err       = r_err;
  assign o_res_valid = !w_fifo_empty;

  // Loads land at index count; rd_ptr and count are cleared together after every run
  always_ff @(posedge clk) begin
    if (w_load) r_buf[r_count[AW-1:0]] <= i_ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_sent   <= '0;
      r_timer  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) r_count <= r_count + C_ONE;
          if (i_go) begin
            r_err   <= 1'b0;
            r_state <= (r_count != '0) ? ST_START : ST_DONE;
          end
        end
        ST_START: begin
          r_timer <= '0;
          r_state <= eng.eng_error ? ST_ERR : ST_SEND;
        end
        ST_SEND: begin
          if (eng.eng_error || w_timeout) begin
            r_state <= ST_ERR;
          end else if (w_xfer) begin
            r_rd_ptr <= r_rd_ptr + C_ONE;
            r_timer  <= '0;
            r_state  <= ST_WAIT;
          end else begin
            r_timer <= r_timer + T_ONE;
          end
        end
        ST_WAIT: begin
          if (eng.eng_error || w_timeout) begin
            r_state <= ST_ERR;
          end else if (w_push) begin
            r_sent  <= w_sent_next;
            r_timer <= '0;
            r_state <= (w_sent_next == r_count) ? ST_DONE : ST_SEND;
          end else begin
            r_timer <= r_timer + T_ONE;
          end
        end
        ST_DONE: begin
          r_count  <= '0;
          r_rd_ptr <= '0;
          r_sent   <= '0;
          r_timer  <= '0;
          r_state  <= ST_IDLE;
        end
        ST_ERR: begin
          r_err    <= 1'b1;
          r_count  <= '0;
          r_rd_ptr <= '0;
          r_sent   <= '0;
          r_timer  <= '0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .W     (W),
    .DEPTH (RDEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (eng.eng_result),
    .i_pop   (i_res_ready),
    .o_data  (o_res_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

endmodule

// File: tb/tb_series_host.sv
// Self-checking bench for series_host: a behavioural engine and consumer run on
// the falling edge; the main sequence drives loads/go and checks outcomes.
module tb_series_host;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_ld_valid;
  logic [W-1:0] i_ld_data;
  logic         o_ld_ready;
  logic         i_go;
  logic         o_res_valid;
  logic [W-1:0] o_res_data;
  logic         i_res_ready;
  logic         o_busy;
  logic         o_done;
  logic         o_err;

  series_host_if #(.W(W)) eng ();

  series_host #(.W(W), .DEPTH(8), .RDEPTH(4), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ld_valid  (i_ld_valid),
    .i_ld_data   (i_ld_data),
    .o_ld_ready  (o_ld_ready),
    .i_go        (i_go),
    .eng         (eng),
    .o_res_valid (o_res_valid),
    .o_res_data  (o_res_data),
    .i_res_ready (i_res_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;

  // Knobs written only by the main sequence
  logic [15:0] eng_mul   = 16'd1;
  int          stall_at  = -1;
  int          stall_len = 0;
  int          err_at    = -1;
  int          pop_limit = 1 << 30;
  bit          rand_mode = 1'b0;

  // Observations written only by the engine/consumer model
  logic [15:0] acc_q [$];
  logic [15:0] got_q [$];
  int          done_cnt, start_cnt, held_cnt, xchg_cnt, drop_cnt;
  bit          held, pend, op_seen;
  int          stall_left, pend_wait, pend_idx;
  logic [15:0] held_x, pend_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Engine: accepts operands (optionally stalling), returns x*eng_mul after a
  // delay, may flag an error instead of a result. Consumer pops up to pop_limit.
  always @(negedge clk) begin
    if (rst) begin
      eng.eng_ready     = 1'b0;
      eng.eng_out_valid = 1'b0;
      eng.eng_error     = 1'b0;
      eng.eng_result    = '0;
      i_res_ready       = 1'b0;
      held = 1'b0; pend = 1'b0; op_seen = 1'b0;
    end else begin
      if (o_done) done_cnt++;
      if (eng.eng_start) start_cnt++;
      if (held) begin
        if (!eng.eng_in_valid) drop_cnt++;
        else if (eng.eng_x != held_x) xchg_cnt++;
      end
      i_res_ready = 1'b0;
      if (o_res_valid && got_q.size() < pop_limit && (!rand_mode || $urandom_range(1, 0) == 1)) begin
        got_q.push_back(o_res_data);
        i_res_ready = 1'b1;
      end
      eng.eng_out_valid = 1'b0;
      eng.eng_error     = 1'b0;
      if (pend) begin
        if (pend_wait > 0) pend_wait--;
        else begin
          pend              = 1'b0;
          eng.eng_out_valid = 1'b1;
          eng.eng_result    = pend_val;
          if (pend_idx == err_at) eng.eng_error = 1'b1;
        end
      end
      eng.eng_ready = 1'b0;
      if (eng.eng_in_valid) begin
        if (!op_seen) begin
          op_seen    = 1'b1;
          stall_left = (acc_q.size() == stall_at) ? stall_len :
                       rand_mode ? int'($urandom_range(3, 0)) : 0;
        end
        if (stall_left > 0) stall_left--;
        else eng.eng_ready = 1'b1;
      end
      held   = eng.eng_in_valid && !eng.eng_ready;
      held_x = eng.eng_x;
      if (held) held_cnt++;
      if (eng.eng_in_valid && eng.eng_ready) begin
        pend      = 1'b1;
        pend_wait = rand_mode ? int'($urandom_range(2, 0)) : 0;
        pend_val  = eng.eng_x * eng_mul;
        pend_idx  = acc_q.size();
        acc_q.push_back(eng.eng_x);
        op_seen   = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " ld_ready"},  o_ld_ready,        1);
    check({tag, " start"},     eng.eng_start,     0);
    check({tag, " in_valid"},  eng.eng_in_valid,  0);
    check({tag, " eng_x"},     eng.eng_x,         0);
    check({tag, " res_valid"}, o_res_valid,       0);
    check({tag, " res_data"},  o_res_data,        0);
    check({tag, " busy"},      o_busy,            0);
    check({tag, " done"},      o_done,            0);
    check({tag, " err"},       o_err,             0);
  endtask

  task automatic load_ops(input int n, input logic [15:0] ops [8]);
    for (int i = 0; i < n; i++) begin
      i_ld_valid = 1'b1;
      i_ld_data  = ops[i];
      @(negedge clk);
    end
    i_ld_valid = 1'b0;
  endtask

  task automatic pulse_go();
    i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
  endtask

  // Complete run: expected results are supplied by the caller, in load order
  task automatic run_job(input string tag, input int n, input logic [15:0] mul, input bit extra,
                         input int s_idx, input int s_len, input logic [15:0] ops [8],
                         input logic [15:0] exp [8], input int exp_hold);
    int b_done, b_start, b_hold, b_x, b_drop, b_acc, b_got, t;
    b_done = done_cnt; b_start = start_cnt; b_hold = held_cnt; b_x = xchg_cnt; b_drop = drop_cnt;
    b_acc  = acc_q.size(); b_got = got_q.size();
    eng_mul   = mul;
    stall_at  = (s_idx >= 0) ? b_acc + s_idx : -1;
    stall_len = s_len;
    load_ops(n, ops);
    if (extra) begin
      check({tag, " ld_ready after full"}, o_ld_ready, 0);
      i_ld_valid = 1'b1;
      i_ld_data  = 16'h0099;
      @(negedge clk);
      i_ld_valid = 1'b0;
    end
    pulse_go();
    check({tag, " start pulse"}, eng.eng_start, 1);
    check({tag, " err cleared"}, o_err, 0);
    @(negedge clk);
    check({tag, " start single"}, eng.eng_start, 0);
    check({tag, " first in_valid"}, eng.eng_in_valid, 1);
    t = 0;
    while (got_q.size() < b_got + n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check({tag, " busy dropped"}, o_busy, 0);
    check({tag, " result count"}, got_q.size() - b_got, n);
    check({tag, " done pulses"}, done_cnt - b_done, 1);
    check({tag, " start pulses"}, start_cnt - b_start, 1);
    check({tag, " operands sent"}, acc_q.size() - b_acc, n);
    for (int i = 0; i < n && b_got + i < got_q.size(); i++)
      check($sformatf("%s result[%0d]", tag, i), got_q[b_got + i], exp[i]);
    for (int i = 0; i < n && b_acc + i < acc_q.size(); i++)
      check($sformatf("%s eng_x[%0d]", tag, i), acc_q[b_acc + i], ops[i]);
    if (exp_hold >= 0) check({tag, " stall cycles"}, held_cnt - b_hold, exp_hold);
    check({tag, " eng_x stable"}, xchg_cnt - b_x, 0);
    check({tag, " in_valid held"}, drop_cnt - b_drop, 0);
    stall_at = -1;
  endtask

  typedef struct {
    int          n;
    logic [15:0] mul;
    bit          extra;
    int          stall_idx;
    int          stall_len;
    int          exp_hold;
    logic [15:0] ops [8];
    logic [15:0] exp [8];
  } vec_t;

  vec_t        vecs [4];
  logic [15:0] ops [8];
  logic [15:0] exp [8];
  logic [15:0] mul;
  int          n, t, b_done, b_start, b_acc, b_got;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3, 16'd2, 1'b0, -1, 0, 0,
                '{16'd3, 16'd5, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                '{16'd6, 16'd10, 16'd14, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
    vecs[1] = '{8, 16'd3, 1'b1, -1, 0, 0,
                '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8},
                '{16'd3, 16'd6, 16'd9, 16'd12, 16'd15, 16'd18, 16'd21, 16'd24}};
    vecs[2] = '{2, 16'd2, 1'b0, 0, 5, 5,
                '{16'hFFFF, 16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                '{16'hFFFE, 16'h0000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
    vecs[3] = '{4, 16'h0010, 1'b0, 2, 1, 1,
                '{16'h0000, 16'h0001, 16'h00FF, 16'h1234, 16'd0, 16'd0, 16'd0, 16'd0},
                '{16'h0000, 16'h0010, 16'h0FF0, 16'h2340, 16'd0, 16'd0, 16'd0, 16'd0}};

    rst = 1'b1; i_ld_valid = 1'b0; i_ld_data = '0; i_go = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Empty buffer: go yields done one cycle later and never starts the engine
    b_start = start_cnt;
    pulse_go();
    check("empty go done", o_done, 1);
    check("empty go no start", eng.eng_start, 0);
    @(negedge clk);
    check("empty go done single", o_done, 0);
    check("empty go idle", o_busy, 0);
    check("empty go start count", start_cnt - b_start, 0);

    for (int v = 0; v < 4; v++)
      run_job($sformatf("vec%0d", v), vecs[v].n, vecs[v].mul, vecs[v].extra, vecs[v].stall_idx,
              vecs[v].stall_len, vecs[v].ops, vecs[v].exp, vecs[v].exp_hold);

    // Result FIFO full: no sends until a pop, then a long stall times out
    b_done = done_cnt; b_acc = acc_q.size(); b_got = got_q.size();
    pop_limit = b_got;
    eng_mul = 16'd5;
    for (int i = 0; i < 8; i++) ops[i] = 16'($urandom);
    load_ops(6, ops);
    pulse_go();
    repeat (30) @(negedge clk);
    check("full stall in_valid", eng.eng_in_valid, 0);
    check("full stall sent", acc_q.size() - b_acc, 4);
    check("full stall busy", o_busy, 1);
    pop_limit = b_got + 1;
    t = 0;
    while (acc_q.size() - b_acc < 5 && t < 20) begin @(negedge clk); t++; end
    check("pop releases 5th", acc_q.size() - b_acc, 5);
    t = 0;
    while (o_busy && t < 200) begin @(negedge clk); t++; end
    check("timeout err", o_err, 1);
    check("timeout busy", o_busy, 0);
    check("timeout no done", done_cnt - b_done, 0);
    check("timeout buffer cleared", o_ld_ready, 1);
    pop_limit = 1 << 30;
    repeat (10) @(negedge clk);
    check("timeout drained count", got_q.size() - b_got, 5);
    for (int i = 0; i < 5 && b_got + i < got_q.size(); i++)
      check($sformatf("timeout drained[%0d]", i), got_q[b_got + i], 16'(ops[i] * 16'd5));

    // Engine error in the WAIT of the second operand
    b_done = done_cnt; b_acc = acc_q.size(); b_got = got_q.size();
    eng_mul = 16'd7;
    err_at  = b_acc + 1;
    ops[0] = 16'd11; ops[1] = 16'd22; ops[2] = 16'd33;
    load_ops(3, ops);
    pulse_go();
    t = 0;
    while (o_busy && t < 100) begin @(negedge clk); t++; end
    check("eng_error err", o_err, 1);
    check("eng_error sent", acc_q.size() - b_acc, 2);
    check("eng_error no done", done_cnt - b_done, 0);
    repeat (3) @(negedge clk);
    err_at = -1;
    check("eng_error results", got_q.size() - b_got, 1);
    if (got_q.size() > b_got) check("eng_error first result", got_q[b_got], 16'd77);
    check("eng_error ld_ready", o_ld_ready, 1);
    run_job("after_err", vecs[0].n, vecs[0].mul, 1'b0, -1, 0, vecs[0].ops, vecs[0].exp, 0);

    // Randomized runs against the reference: results are x*mul in load order
    rand_mode = 1'b1;
    for (int j = 0; j < 15; j++) begin
      n   = $urandom_range(8, 1);
      mul = 16'($urandom) | 16'h0001;
      for (int i = 0; i < 8; i++) begin
        ops[i] = 16'($urandom);
        exp[i] = 16'(ops[i] * mul);
      end
      run_job($sformatf("rnd%0d", j), n, mul, 1'b0, -1, 0, ops, exp, -1);
    end
    rand_mode = 1'b0;

    // Asynchronous reset while stalled in SEND with a result queued
    pop_limit = got_q.size();
    eng_mul   = 16'd1;
    stall_at  = acc_q.size() + 1;
    stall_len = 50;
    ops[0] = 16'd5; ops[1] = 16'd6;
    load_ops(2, ops);
    pulse_go();
    repeat (6) @(negedge clk);
    check("pre-rst in_valid", eng.eng_in_valid, 1);
    check("pre-rst res_valid", o_res_valid, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid-send rst");
    @(negedge clk);
    stall_at  = -1;
    pop_limit = 1 << 30;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post-rst idle", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
